// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a byte stream MSB-first into words and writes them from address 0.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter  int WORD_SIZE = 32,
    parameter  int DEPTH     = 256,
    localparam int AW        = $clog2(DEPTH),
    localparam int BPW       = WORD_SIZE / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AW:0]          load_len_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    output logic                 byte_ready_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 core_rst_n_o
);

    localparam int          CW      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [AW:0]          len_q, len_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic [AW:0]          len_clamped_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
    logic                 err_q, err_d;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // Requested length clamped to the memory depth so writes can never wrap.
    always_comb begin
        if (load_len_i > DEPTH_W) begin
            len_clamped_s = DEPTH_W;
        end else begin
            len_clamped_s = load_len_i;
        end
    end

    // Next-state and datapath updates for the load sequence.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        core_rst_n_d = core_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d        = len_clamped_s;
                    addr_d       = '0;
                    cnt_d        = '0;
                    shift_d      = '0;
                    core_rst_n_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = 8'h00;
                    err_d        = 1'b0;
`endif
                    if (len_clamped_s == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (byte_valid_i) begin
                    shift_d = {shift_q[WORD_SIZE-9:0], byte_data_i};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_fold(csum_q, byte_data_i);
`endif
                    if (cnt_q == CW'(BPW - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                if ({1'b0, addr_q} == (len_q - 1'b1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_valid_i) begin
                    err_d   = (byte_data_i != csum_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_DONE: begin
                done_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                core_rst_n_d = ~err_q;
`else
                core_rst_n_d = 1'b1;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered busy covers the cycle after start through the registered done pulse.
        busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'h00;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            err_q        <= err_d;
`endif
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready_o = (state_q == ST_RECV) || (state_q == ST_CHECK);
    assign err_o        = err_q;
`else
    assign byte_ready_o = (state_q == ST_RECV);
    assign err_o        = 1'b0;
`endif
    assign mem_we_o     = (state_q == ST_WRITE);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = shift_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign core_rst_n_o = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads checked against a byte-to-word reference model.
module tb_imem_loader;

    localparam int WS    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int BPW   = WS / 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready, mem_we, busy, done, err, core_rst_n;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]    stim[$];
    logic [AW-1:0] wr_addr[$];
    logic [WS-1:0] wr_data[$];
    int            wr_cyc[$];
    int            done_cyc = 0;
    int            done_cnt = 0;

    imem_loader #(.WORD_SIZE(WS), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .load_len_i(load_len),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .core_rst_n_o(core_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (rst_n && done) begin
            done_cyc = cyc;
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic fill_random(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    // Reference word k: BPW stream bytes, first byte most significant.
    function automatic logic [WS-1:0] model_word(input int k);
        longint w = 0;
        for (int j = 0; j < BPW; j++) w = w * 256 + longint'(stim[k*BPW + j]);
        return WS'(w);
    endfunction

    task automatic send_byte(input logic [7:0] b, output bit ok);
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start(input int len_in, output int s);
        @(posedge clk); #1;
        start    = 1'b1;
        load_len = len_in[AW:0];
        s        = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
        load_len = (AW+1)'($urandom);
    endtask

    task automatic run_load(input string tag, input int len_in, input bit toggle,
                            input bit poke, input bit bad_csum);
        int n, s, exp_err;
        bit ok;
        logic [7:0] cs;
        n  = (len_in > DEPTH) ? DEPTH : len_in;
        cs = 8'h00;
        clear_mon();
        do_start(len_in, s);
        for (int i = 0; i < n*BPW; i++) begin
            if (poke && i == 2) begin
                start    = 1'b1;
                load_len = (AW+1)'(3);
            end
            send_byte(stim[i], ok);
            start = 1'b0;
            if (!ok) check({tag, "_byte_timeout"}, 64'd0, 64'd1);
            cs = cs ^ stim[i];
            if (toggle) begin
                byte_valid = 1'b0;
                byte_data  = ~stim[i];
                @(posedge clk); #1;
            end
        end
        if (CS == 1 && n > 0) begin
            send_byte(bad_csum ? (cs ^ 8'h01) : cs, ok);
            if (!ok) check({tag, "_csum_timeout"}, 64'd0, 64'd1);
        end
        byte_valid = 1'b0;
        for (int t = 0; t < 3000 && done_cnt == 0; t++) @(posedge clk);
        #1;
        @(negedge clk);
        exp_err = (CS == 1 && n > 0 && bad_csum) ? 1 : 0;
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_write_count"}, 64'(wr_addr.size()), 64'(n));
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), 64'(wr_addr[k]), 64'(k));
            check($sformatf("%s_data%0d", tag, k), 64'(wr_data[k]), 64'(model_word(k)));
        end
        if (!toggle && !poke) begin
            check({tag, "_done_latency"}, 64'(done_cyc - s),
                  64'(1 + n*(BPW+1) + ((n > 0) ? CS : 0) + 1));
            if (n >= 2 && wr_cyc.size() >= 2)
                check({tag, "_write_spacing"}, 64'(wr_cyc[1] - wr_cyc[0]), 64'(BPW + 1));
        end
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(exp_err == 0));
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
    endtask

    initial begin
        int s;
        bit ok;

        // Power-on reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset after two bytes of word 0, then a clean one-word load.
        clear_mon();
        do_start(1, s);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        @(posedge clk); #1;
        send_byte(8'h01, ok);
        send_byte(8'h02, ok);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_no_writes", 64'(wr_addr.size()), 64'd0);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("one_word", 1, 1'b0, 1'b0, 1'b0);

        // Two directed words, continuous and then with gaps.
        stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_load("two_word", 2, 1'b0, 1'b0, 1'b0);
        run_load("two_word_toggle", 2, 1'b1, 1'b0, 1'b0);

        // Empty load.
        stim.delete();
        run_load("len0", 0, 1'b0, 1'b0, 1'b0);

        // start pulsed mid-load is ignored.
        fill_random(3*BPW);
        run_load("poke", 3, 1'b0, 1'b1, 1'b0);

        // Random loads.
        for (int r = 0; r < 4; r++) begin
            int len_r;
            bit tog;
            len_r = int'($urandom_range(1, 6));
            tog   = 1'($urandom);
            fill_random(len_r*BPW);
            run_load($sformatf("rand%0d", r), len_r, tog, 1'b0, 1'b0);
        end

        // Clamped load fills every address exactly once.
        fill_random(DEPTH*BPW);
        run_load("clamp", DEPTH + 5, 1'b0, 1'b0, 1'b0);

        // Asynchronous deassertion of mem_we during a write cycle.
        clear_mon();
        do_start(1, s);
        send_byte(8'hAA, ok);
        send_byte(8'hBB, ok);
        send_byte(8'hCC, ok);
        send_byte(8'hDD, ok);
        byte_valid = 1'b0;
        #1 check("we_in_write", 64'(mem_we), 64'd1);
        check("wdata_in_write", 64'(mem_wdata), 64'hAABBCCDD);
        rst_n = 1'b0;
        #1 check("we_async_drop", 64'(mem_we), 64'd0);
        check("core_rst_async", 64'(core_rst_n), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("csum_good", 1, 1'b0, 1'b0, 1'b0);
        run_load("csum_bad", 1, 1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("csum_bad_sticky_err", 64'(err), 64'd1);
        check("csum_bad_hold_core", 64'(core_rst_n), 64'd0);
        stim.delete();
        run_load("after_bad_len0", 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
